shift_right_seq: RTL
====================

# shift_right_seq

Multi-cycle right shifter: the counterpart to the team's combinational left shifter in the ALU shift path. It shifts operand `A` right by the amount in `B`, one bit position per clock, and uses a start/busy/done handshake. It serves the multi-cycle datapath as the SRL/SRA execution unit. Control logic issues an operation and waits for `done`, rather than paying a 32-way mux tree in the critical path.

## Interface
- `N`, default 32: operand width; shift amount is interpreted as unsigned `B[N-1:0]`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled on a rising edge when not busy.
- `A`  in  N  value to shift; sampled with `start`.
- `B`  in  N  shift amount, unsigned; sampled with `start`.
- `arith`  in  1  1 = arithmetic (sign fill), 0 = logical (zero fill); sampled with `start`.
- `busy`  out  1  high while a shift is in progress.
- `done`  out  1  one-cycle pulse; `Z` is valid from this cycle on.
- `Z`  out  N  registered result; held until the next completion.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- Accept: `start`=1 at an edge while in IDLE or DONE. `start` is ignored in SHIFT, and no buffering is done.
- On accept at edge t0:
  - Capture `A` into the working register `W`.
  - Capture fill bit `f` = `arith & A[N-1]`.
  - Capture count `k` = `B`.
- Branch on `k` at t0:
  - `k`=0: `Z`←`A`, go to DONE.
  - `k`≥N: `Z`←all bits `f`, go to DONE. The comparison uses the full N-bit `B`, so upper bits are not truncated.
  - 1≤`k`≤N-1: go to SHIFT.
- SHIFT, each edge:
  - `W`←{`f`, `W[N-1:1]`}, count decrements.
  - When count==1 at an edge: `Z`←shifted value, go to DONE.
- DONE: `done`=1 for exactly one cycle.
  - Next state is IDLE.
  - If `start`=1 in DONE, it is accepted as from IDLE.
- `busy`=1 iff state==SHIFT.
- `Z` changes only on entry to DONE. Partial values are never visible.
- Reset, asynchronous, at any time including mid-SHIFT:
  - state←IDLE, `busy`=0, `done`=0, `Z`=0.
  - `W` and count cleared; the in-flight operation is discarded.

## Timing
- Latency counts from the accepting edge t0 to the edge that enters DONE.
  - 0 edges for `k`=0 or `k`≥N: `done` is high in the cycle right after t0.
  - `k` edges for 1≤`k`≤N-1.
- Worst case is `k`=N-1 (31 at default): `busy` is high for 31 cycles.
- Back-to-back issue: holding `start` high in a DONE cycle gives zero idle cycles between operations.
- All outputs are registered, so there is no combinational path from inputs to outputs.
- Reset values: `busy`=0, `done`=0, `Z`=0.

## Configuration
- `SHIFT_RIGHT_ARITH_EN` defined: `arith` is honored and `f`=`arith & A[N-1]`. SRA and SRL are both supported.
- Undefined: the `arith` port remains but is ignored, and `f`=0 always (SRL only). The sign-fill logic is removed from synthesis.

## Test plan
- `A`=0xF0000000, `B`=4, `arith`=0:
  - `busy` is high for 4 cycles.
  - `done` pulses after edge t0+4.
  - `Z`=0x0F000000.
- Same inputs with `arith`=1 (macro defined): `Z`=0xFF000000 with the same timing. With the macro undefined: `Z`=0x0F000000.
- `B`=0, `A`=0x12345678: `done` is high in the cycle after t0, `busy` never rises, `Z`=0x12345678.
- `A`=0x80000001, `B`=0x00000028 (40):
  - With `arith`=1: `Z`=0xFFFFFFFF.
  - With `arith`=0: `Z`=0.
  - `B`=0x00010001 gives the same result as `B`=40 (≥N, not 1).
  - Latency is 0 edges in all cases.
- `start` pulsed with new operands during SHIFT: the first result and its timing are unaffected. Then `start` held through DONE: the second operation is accepted with no idle cycle.
- `rst` asserted mid-SHIFT, away from any clock edge: `busy`, `done` and `Z` drop to 0 immediately. After release, no `done` appears until a new `start`.

Source files
------------

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter (SRL/SRA) with start/busy/done handshake, one bit per clock.
// Optional sign fill is enabled by defining SHIFT_RIGHT_ARITH_EN; otherwise zero fill only.
module shift_right_seq #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         arith,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Z
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [N-1:0] N_VAL = N'(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  w, w_nxt;
  logic [N-1:0]  z_nxt;
  logic [N-1:0]  shifted;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          fill, fill_nxt;
  logic          fill_in;

`ifdef SHIFT_RIGHT_ARITH_EN
  assign fill_in = arith & A[N-1];
`else
  logic unused_arith;
  assign unused_arith = arith;
  assign fill_in      = 1'b0;
`endif

  assign shifted = {fill, w[N-1:1]};

  // Next-state and datapath update; start is honoured in IDLE and DONE only
  always_comb begin
    state_nxt = state;
    w_nxt     = w;
    fill_nxt  = fill;
    cnt_nxt   = cnt;
    z_nxt     = Z;
    case (state)
      SHIFT: begin
        w_nxt   = shifted;
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          z_nxt     = shifted;
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        if (start) begin
          w_nxt    = A;
          fill_nxt = fill_in;
          cnt_nxt  = CW'(B);
          if (B == '0) begin
            z_nxt     = A;
            state_nxt = DONE;
          end else if (B >= N_VAL) begin
            z_nxt     = {N{fill_in}};
            state_nxt = DONE;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      w     <= '0;
      fill  <= 1'b0;
      cnt   <= '0;
      Z     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      w     <= w_nxt;
      fill  <= fill_nxt;
      cnt   <= cnt_nxt;
      Z     <= z_nxt;
      busy  <= (state_nxt == SHIFT);
      done  <= (state_nxt == DONE);
    end
  end

endmodule
